cim_tile_accum: RTL and testbench
=================================

// Module: cim_tile_accum
// PURPOSE
//  Parametrised, pipelined successor to the combinational CIM tile adder.
//  Accumulates TILE x TILE signed Winograd output tiles from the PE array into an
//  on-chip buffer of DEPTH tiles, indexed by address.
//  Emits the finished tile on a valid/ready result port when the beat is flagged last.
//  Sits between the PE array and the memory write-back path.
// PARAMETERS
//  TILE    6    tile edge; a tile has TILE*TILE elements
//  DATA_W  12   signed element width, two's complement
//  ADDR_W  8    buffer address width
//  DEPTH   64   tiles held in buffer; DEPTH <= 2**ADDR_W
//  BUS_W   512  packed bus width; elaboration error if BUS_W < TILE*TILE*DATA_W
// PORTS
//  clock          in   1       single clock, rising edge
//  reset          in   1       synchronous, active-high
//  pe_valid_i     in   1       PE beat valid
//  pe_ready_o     out  1       block accepts beat
//  pe_tile_i      in   BUS_W   packed tile: element (i,j) at bits [(i*TILE+j)*DATA_W +: DATA_W]
//  pe_addr_i      in   ADDR_W  buffer entry
//  pe_first_i     in   1       treat stored value as zero (start new accumulation)
//  pe_last_i      in   1       emit accumulated tile after this beat
//  result_valid_o out  1       result held
//  result_ready_i in   1       consumer accepts result
//  result_o       out  BUS_W   accumulated tile, same packing; pad bits are 0
//  result_addr_o  out  ADDR_W  address of result tile
//  addr_err_o     out  1       sticky: a beat with pe_addr_i >= DEPTH was accepted
// BEHAVIOUR
//  Reset values: result_valid_o=0, result_o=0, result_addr_o=0, addr_err_o=0, stage A empty, all entry-valid bits 0.
//    Buffer data array is not reset.
//  Handshake: beat accepted on an edge with pe_valid_i && pe_ready_o.
//    result transfers on an edge with result_valid_o && result_ready_i.
//  Stage A (acceptance edge k): register tile, addr, first, last.
//    Also register old = buffer[pe_addr_i], forced to 0 if the entry is invalid or pe_first_i.
//    Bypass: if A is valid, A writes this edge, and A.addr==pe_addr_i, then old = sum_A unless pe_first_i.
//  sum_A = per-element old + tile. Each element is DATA_W bits and wraps (two's complement).
//  Stage B (edge k+1): buffer[A.addr] <= sum_A and the entry-valid bit is set.
//    If A.last: result_o <= sum_A (zero-padded), result_addr_o <= A.addr, result_valid_o <= 1.
//    Latency: accept at edge k gives result_valid_o high after edge k+1.
//  Stall: stall = A.valid && A.last && result_valid_o && !result_ready_i.
//    pe_ready_o = !stall. A freezes and no write occurs while stalled.
//  Result release and reload on the same edge (ready high while A.last) is allowed; no bubble.
//  result_valid_o clears on transfer when no new last tile loads on that edge.
//  Out-of-range addr (>= DEPTH): beat is accepted, no buffer write, addr_err_o set.
//    If the beat is last, a result is still emitted with sum = tile.
//  Back-to-back beats to the same addr accumulate correctly through the bypass at full throughput.
//  Reset mid-operation: in-flight A and any pending result are dropped; all entries become invalid.
// CONFIGURATION
//  CIM_ACCUM_SAT_EN defined: saturate each element sum to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
//  CIM_ACCUM_SAT_EN undefined: element sums wrap modulo 2**DATA_W. Timing and handshake are identical.
// STRUCTURE
//  cim_pkg holds TILE/DATA_W/BUS_W defaults, typedef elem_t (signed DATA_W), typedef tile_t (elem_t [TILE][TILE]),
//    and pack/unpack functions.
//  One sub-module: cim_tile_adder. It is combinational and does the element-wise add, with wrap or sat under CIM_ACCUM_SAT_EN.
// TESTING
//  1 Reset, idle -> result_valid_o=0, pe_ready_o=1, addr_err_o=0, result_o=0.
//  2 One beat, addr 3, first+last, all elements 5 -> after next edge: result_valid_o=1, addr 3,
//    every element 5, bits [511:432]=0.
//  3 Beats to addr 7 on consecutive cycles: 100 (first), -20, 7 (last) -> single result, all elements 87 (bypass path).
//  4 Elements 2047 then +1 to the same addr, last -> -2048 without macro, 2047 with CIM_ACCUM_SAT_EN.
//    -2048 + -1 -> 2047 without macro, -2048 with it.
//  5 result_ready_i=0 for 5 cycles while a second last beat is queued -> result_o stable, pe_ready_o=0,
//    no beat lost, both results delivered in order.
//  6 Accumulate addr 2 to 50, assert reset, then a non-first last beat of 9 to addr 2 -> result 9.
//    Also: addr 200 accepted -> addr_err_o=1 stays set until reset.

Source files
------------

// File: rtl/cim_tile_accum_pkg.sv
// Shared types and defaults for the CIM tile accumulator.
// Optional saturation is enabled with CIM_ACCUM_SAT_EN.
package cim_pkg;

  localparam int TILE   = 6;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;
  localparam int BUS_W  = 512;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t tile_t [TILE][TILE];

  function automatic logic [BUS_W-1:0] pack_tile(
    input tile_t t
  );
    logic [BUS_W-1:0] b;
    b = '0;
    for (int i = 0; i < TILE; i++)
      for (int j = 0; j < TILE; j++)
        b[(i*TILE+j)*DATA_W +: DATA_W] = t[i][j];
    return b;
  endfunction

  function automatic void unpack_tile(
    input  logic [BUS_W-1:0] b,
    output tile_t            t
  );
    for (int i = 0; i < TILE; i++)
      for (int j = 0; j < TILE; j++)
        t[i][j] = b[(i*TILE+j)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/cim_tile_accum_if.sv
// PE beat and result handshake bundle for cim_tile_accum.
// Optional saturation is enabled with CIM_ACCUM_SAT_EN.
interface cim_tile_accum_if #(
  parameter int ADDR_W = cim_pkg::ADDR_W,
  parameter int BUS_W  = cim_pkg::BUS_W
);

  logic              pe_valid_i;
  logic              pe_ready_o;
  logic [BUS_W-1:0]  pe_tile_i;
  logic [ADDR_W-1:0] pe_addr_i;
  logic              pe_first_i;
  logic              pe_last_i;
  logic              result_valid_o;
  logic              result_ready_i;
  logic [BUS_W-1:0]  result_o;
  logic [ADDR_W-1:0] result_addr_o;
  logic              addr_err_o;

  modport master (
    output pe_valid_i, pe_tile_i, pe_addr_i,
    output pe_first_i, pe_last_i, result_ready_i,
    input  pe_ready_o, result_valid_o, result_o,
    input  result_addr_o, addr_err_o
  );

  modport slave (
    input  pe_valid_i, pe_tile_i, pe_addr_i,
    input  pe_first_i, pe_last_i, result_ready_i,
    output pe_ready_o, result_valid_o, result_o,
    output result_addr_o, addr_err_o
  );

endinterface

// File: rtl/cim_tile_adder.sv
// Element-wise signed tile adder, wrapping by default.
// CIM_ACCUM_SAT_EN switches each element to saturating add.
module cim_tile_adder #(
  parameter int TILE   = cim_pkg::TILE,
  parameter int DATA_W = cim_pkg::DATA_W
) (
  input  logic [TILE*TILE*DATA_W-1:0] a_i,
  input  logic [TILE*TILE*DATA_W-1:0] b_i,
  output logic [TILE*TILE*DATA_W-1:0] sum_o
);

  import cim_pkg::*;

  for (genvar e = 0; e < TILE*TILE; e++) begin : g_el
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    assign a = a_i[e*DATA_W +: DATA_W];
    assign b = b_i[e*DATA_W +: DATA_W];
`ifdef CIM_ACCUM_SAT_EN
    logic [DATA_W:0] s;
    assign s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    // sign bits disagree: clamp toward the true sign
    assign sum_o[e*DATA_W +: DATA_W] =
      (s[DATA_W] ^ s[DATA_W-1]) ?
      {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} :
      s[DATA_W-1:0];
`else
    assign sum_o[e*DATA_W +: DATA_W] = a + b;
`endif
  end

endmodule

// File: rtl/cim_tile_accum.sv
// Pipelined CIM tile accumulator with bypass and result port.
// Optional saturation is enabled with CIM_ACCUM_SAT_EN.
module cim_tile_accum #(
  parameter int TILE   = cim_pkg::TILE,
  parameter int DATA_W = cim_pkg::DATA_W,
  parameter int ADDR_W = cim_pkg::ADDR_W,
  parameter int DEPTH  = cim_pkg::DEPTH,
  parameter int BUS_W  = cim_pkg::BUS_W
) (
  input logic          clock,
  input logic          reset,
  cim_tile_accum_if.slave bus
);

  import cim_pkg::*;

  localparam int EW = TILE*TILE*DATA_W;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);

  if (BUS_W < EW) begin : g_bus_chk
    $error("BUS_W narrower than one tile");
  end

  logic [EW-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0]  ent_vld_q;
  logic              a_vld_q;
  logic              a_last_q;
  logic              a_oob_q;
  logic [ADDR_W-1:0] a_addr_q;
  logic [EW-1:0]     a_tile_q;
  logic [EW-1:0]     a_old_q;
  logic [EW-1:0]     a_old_d;
  logic [EW-1:0]     a_sum;
  logic              res_vld_q;
  logic [BUS_W-1:0]  res_q;
  logic [ADDR_W-1:0] res_addr_q;
  logic              err_q;
  logic              stall;
  logic              accept;
  logic              a_move;
  logic              in_oob;
  logic [IW-1:0]     in_idx;
  logic [IW-1:0]     a_idx;
  logic              unused_pad;

  cim_tile_adder #(
    .TILE  (TILE),
    .DATA_W(DATA_W)
  ) u_add (
    .a_i  (a_old_q),
    .b_i  (a_tile_q),
    .sum_o(a_sum)
  );

  assign stall  = a_vld_q && a_last_q && res_vld_q
               && !bus.result_ready_i;
  assign accept = bus.pe_valid_i && !stall;
  assign a_move = a_vld_q && !stall;
  assign in_oob = {1'b0, bus.pe_addr_i} >= DEPTH_L;
  assign in_idx = bus.pe_addr_i[IW-1:0];
  assign a_idx  = a_addr_q[IW-1:0];
  assign unused_pad = ^bus.pe_tile_i;

  // stage A's pending write wins over the stale buffer copy
  always_comb begin
    a_old_d = '0;
    if (!bus.pe_first_i && !in_oob) begin
      if (a_move && !a_oob_q &&
          a_addr_q == bus.pe_addr_i)
        a_old_d = a_sum;
      else if (ent_vld_q[in_idx])
        a_old_d = mem_q[in_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_vld_q    <= 1'b0;
      ent_vld_q  <= '0;
      res_vld_q  <= 1'b0;
      res_q      <= '0;
      res_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (!stall)
        a_vld_q <= bus.pe_valid_i;
      if (a_move && !a_oob_q)
        ent_vld_q[a_idx] <= 1'b1;
      if (accept && in_oob)
        err_q <= 1'b1;
      if (a_move && a_last_q) begin
        res_vld_q  <= 1'b1;
        res_q      <= BUS_W'(a_sum);
        res_addr_q <= a_addr_q;
      end else if (bus.result_ready_i) begin
        res_vld_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      a_tile_q <= bus.pe_tile_i[EW-1:0];
      a_old_q  <= a_old_d;
      a_addr_q <= bus.pe_addr_i;
      a_last_q <= bus.pe_last_i;
      a_oob_q  <= in_oob;
    end
    if (a_move && !a_oob_q)
      mem_q[a_idx] <= a_sum;
  end

  assign bus.pe_ready_o     = !stall;
  assign bus.result_valid_o = res_vld_q;
  assign bus.result_o       = res_q;
  assign bus.result_addr_o  = res_addr_q;
  assign bus.addr_err_o     = err_q;

endmodule

// File: tb/tb_cim_tile_accum.sv
// Scoreboard bench for cim_tile_accum.
// Expected saturation results follow CIM_ACCUM_SAT_EN.
module tb_cim_tile_accum;

  import cim_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cim_tile_accum_if bus ();

  cim_tile_accum dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [BUS_W-1:0]  data;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [BUS_W-1:0] uni(int v);
    tile_t t;
    for (int i = 0; i < TILE; i++)
      for (int j = 0; j < TILE; j++)
        t[i][j] = elem_t'(v);
    return pack_tile(t);
  endfunction

  // element (i,j) = k * (3*(i*TILE+j) - 50)
  function automatic logic [BUS_W-1:0] pat(int k);
    tile_t t;
    for (int i = 0; i < TILE; i++)
      for (int j = 0; j < TILE; j++)
        t[i][j] = elem_t'(k * ((i*TILE+j)*3 - 50));
    return pack_tile(t);
  endfunction

  task automatic chk(
    input string            nm,
    input logic [BUS_W-1:0] act,
    input logic [BUS_W-1:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.result_valid_o &&
        bus.result_ready_i) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_result: got addr %0d want none",
                 bus.result_addr_o);
      end else begin
        e = sbq.pop_front();
        chk("res_addr", BUS_W'(bus.result_addr_o),
            BUS_W'(e.addr));
        chk("res_data", bus.result_o, e.data);
      end
    end
  end

  task automatic drive(
    input logic [ADDR_W-1:0] a,
    input logic [BUS_W-1:0]  t,
    input logic              f,
    input logic              l,
    input logic [BUS_W-1:0]  exp,
    input bit                push
  );
    exp_t e;
    bus.pe_valid_i = 1'b1;
    bus.pe_addr_i  = a;
    bus.pe_tile_i  = t;
    bus.pe_first_i = f;
    bus.pe_last_i  = l;
    if (l && push) begin
      e.addr = a;
      e.data = exp;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_acc();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = bus.pe_ready_o;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no ready want ready");
    end
  endtask

  task automatic beat(
    input logic [ADDR_W-1:0] a,
    input logic [BUS_W-1:0]  t,
    input logic              f,
    input logic              l,
    input logic [BUS_W-1:0]  exp,
    input bit                push
  );
    drive(a, t, f, l, exp, push);
    wait_acc();
  endtask

  task automatic idle();
    bus.pe_valid_i = 1'b0;
    bus.pe_first_i = 1'b0;
    bus.pe_last_i  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.pe_addr_i      = '0;
    bus.pe_tile_i      = '0;
    bus.result_ready_i = 1'b1;
    cycles(3);
    rst = 1'b0;

    chk("rst_valid", BUS_W'(bus.result_valid_o), 0);
    chk("rst_ready", BUS_W'(bus.pe_ready_o), 1);
    chk("rst_err", BUS_W'(bus.addr_err_o), 0);
    chk("rst_data", bus.result_o, '0);
    chk("rst_addr", BUS_W'(bus.result_addr_o), 0);

    beat(3, uni(5), 1, 1, uni(5), 1);
    idle();
    cycles(1);
    chk("lat_valid", BUS_W'(bus.result_valid_o), 1);
    chk("lat_addr", BUS_W'(bus.result_addr_o), 3);
    cycles(2);

    beat(7, uni(100), 1, 0, '0, 1);
    beat(7, uni(-20), 0, 0, '0, 1);
    beat(7, uni(7), 0, 1, uni(87), 1);
    idle();
    cycles(2);

`ifdef CIM_ACCUM_SAT_EN
    beat(10, uni(2047), 1, 0, '0, 1);
    beat(10, uni(1), 0, 1, uni(2047), 1);
    beat(11, uni(-2048), 1, 0, '0, 1);
    beat(11, uni(-1), 0, 1, uni(-2048), 1);
`else
    beat(10, uni(2047), 1, 0, '0, 1);
    beat(10, uni(1), 0, 1, uni(-2048), 1);
    beat(11, uni(-2048), 1, 0, '0, 1);
    beat(11, uni(-1), 0, 1, uni(2047), 1);
`endif
    beat(12, pat(1), 1, 0, '0, 1);
    idle();
    cycles(1);
    beat(12, pat(1), 0, 1, pat(2), 1);
    idle();
    cycles(3);

    bus.result_ready_i = 1'b0;
    beat(20, uni(1), 1, 1, uni(1), 1);
    beat(21, uni(2), 1, 1, uni(2), 1);
    drive(22, uni(3), 1, 1, uni(3), 1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_ready", BUS_W'(bus.pe_ready_o), 0);
      chk("stall_valid", BUS_W'(bus.result_valid_o), 1);
      chk("stall_data", bus.result_o, uni(1));
      @(posedge clk);
      #1;
    end
    bus.result_ready_i = 1'b1;
    wait_acc();
    idle();
    cycles(4);

    beat(200, uni(4), 1, 1, uni(4), 1);
    beat(200, uni(4), 0, 1, uni(4), 1);
    beat(8, uni(1), 0, 1, uni(1), 1);
    idle();
    cycles(3);
    chk("err_set", BUS_W'(bus.addr_err_o), 1);
    cycles(3);
    chk("err_sticky", BUS_W'(bus.addr_err_o), 1);

    beat(2, uni(30), 1, 0, '0, 0);
    beat(2, uni(20), 0, 1, '0, 0);
    rst = 1'b1;
    idle();
    cycles(2);
    rst = 1'b0;
    chk("rst2_valid", BUS_W'(bus.result_valid_o), 0);
    chk("rst2_err", BUS_W'(bus.addr_err_o), 0);
    chk("rst2_ready", BUS_W'(bus.pe_ready_o), 1);
    beat(2, uni(9), 0, 1, uni(9), 1);
    idle();

    for (int n = 0; n < 100 && sbq.size() > 0; n++)
      @(posedge clk);
    #1;
    chk("drain", BUS_W'(sbq.size()), 0);
    chk("end_valid", BUS_W'(bus.result_valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
